fp_round_pack_pipe: RTL and testbench
=====================================

# fp_round_pack_pipe

- Parametrised, pipelined successor to the half-precision rounding stage of the FP adder.
- Takes a normalized significand with guard/round/sticky bits, a biased exponent, a sign and special-value flags.
- Applies one of four IEEE-754 rounding modes, selected per transaction, and packs a `1+EXP_W+MAN_W` result with IEEE exception flags.
- Sits between the adder normalizer and the result register, with valid/ready handshakes on both sides.

## Interface

Parameters:
- `EXP_W`, default 5: exponent width.
- `MAN_W`, default 10: stored fraction width.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input transaction valid.
- `in_ready`  out  1: block accepts the input this cycle.
- `in_sign`  in  1: result sign.
- `in_exp`  in  EXP_W: biased exponent. 0 means subnormal.
- `in_mant`  in  MAN_W+4: hidden bit, then MAN_W fraction bits, then G, R, S (LSB).
- `in_rm`  in  2: rounding mode. 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward −inf).
- `in_nan`, `in_inf`  in  1 each: special-value flags.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_result`  out  1+EXP_W+MAN_W: {sign, exp, frac}.
- `out_overflow`, `out_underflow`, `out_inexact`  out  1 each: flags belonging to `out_result`.

## Operation

Stage 1 (rounding):
- L = fraction LSB; `any = G|R|S`.
- Increment `inc` by mode:
  - RNE: `G&(R|S|L)`.
  - RTZ: 0.
  - RUP: `~sign&any`.
  - RDN: `sign&any`.
- `rsig = {hidden, frac} + inc`, computed at MAN_W+2 bits.
- `inexact = any`.

Stage 2 (adjust and pack), in priority order:
- `in_nan`: result is the canonical qNaN {0, all-ones, 1 followed by zeros}. All flags 0. Takes priority over `in_inf`.
- `in_inf`: result is {sign, all-ones, 0}. All flags 0.
- Carry out of `rsig` (bit MAN_W+1): exp+1, frac = 0.
- `in_exp==0` and rounded hidden bit becomes 1: exp = 1 (subnormal promoted to normal).
- Overflow: adjusted exp ≥ all-ones. Sets `overflow=1` and `inexact=1`. Result by mode:
  - RNE: ±inf.
  - RTZ: ±max finite {sign, all-ones−1, all-ones}.
  - RUP: +inf if positive, −max finite if negative.
  - RDN: −inf if negative, +max finite if positive.
- Underflow: final exp == 0 and inexact, with tininess detected after rounding. Exact subnormals and exact zero do not raise it.

All arithmetic is unsigned. The exponent adjust is computed at EXP_W+1 bits so that overflow is visible.

## Timing

- Two-stage pipeline. Latency is 2 cycles from input accept to `out_valid` when not stalled.
- Full throughput: 1 transaction per cycle.
- Input transfer on `in_valid & in_ready`; output transfer on `out_valid & out_ready`.
- `in_ready = ~s1_valid | ~s2_valid | out_ready`. It is combinational and has no path from `in_valid`.
- Stall (`out_valid & ~out_ready`):
  - `out_*` are held stable.
  - Stage 1 holds if it is occupied.
  - Nothing is dropped or duplicated; results leave in order.
- `out_valid` never depends combinationally on `out_ready`.
- Reset, including assertion mid-transaction:
  - Both stage valids clear and in-flight data is discarded.
  - `out_valid=0`, `out_result=0`, all flags 0, `in_ready=1` in the first cycle after reset.
- Flags are registered together with `out_result` and are meaningful only while `out_valid=1`.

## Configuration

- `FP_ROUND_FTZ_EN` defined: flush-to-zero.
  - Any result whose final exp is 0 (subnormal or tiny) becomes {sign, 0, 0}.
  - Both `out_underflow` and `out_inexact` are set if the pre-flush value was nonzero.
- Not defined: full IEEE gradual underflow as described in Operation.

## Test plan

Default parameters (`EXP_W=5`, `MAN_W=10`).

- **Ties to even (RNE):**
  - exp=15, mant {1, 0x001, GRS=100} -> `0x3C02`, inexact=1.
  - exp=15, mant {1, 0x000, GRS=100} -> `0x3C00`, inexact=1.
- **Mantissa carry:** RNE, exp=15, frac=0x3FF, GRS=110 -> `0x4000`, inexact=1, overflow=0.
- **Overflow by mode:** exp=30, frac=0x3FF, GRS=100, sign=0:
  - RNE -> `0x7C00`, overflow=1, inexact=1.
  - RTZ -> `0x7BFF`.
  - Sign=1, RUP -> `0xFBFF`.
- **Subnormal promotion:** RNE, exp=0, mant {0, 0x3FF, GRS=100} -> `0x0400`, underflow=0, inexact=1.
  - With `FP_ROUND_FTZ_EN`, exp=0, mant {0, 0x001, GRS=000} -> `0x0000`, underflow=1.
- **Specials:**
  - `in_nan=1` and `in_inf=1`, sign=1 -> `0x7E00`, flags 0.
  - `in_inf=1`, sign=1 -> `0xFC00`.
- **Backpressure and reset:**
  - 5 back-to-back inputs with `out_ready` low for cycles 3–6 -> `in_ready` drops once both stages are full; all 5 results emerge in order with held values; no loss.
  - `rst_n` pulse mid-stream -> `out_valid=0` asynchronously, and the next accepted input appears 2 cycles later.

Source files
------------

// File: rtl/fp_round_pack_pipe.sv
// ---------------------------------------------------------------------------
// fp_round_pack_pipe
//
// Two-stage rounding and packing pipeline for the FP adder result path.
// Stage 1 applies the selected rounding mode to the normalized significand.
// Stage 2 adjusts the exponent, handles specials and overflow/underflow,
// then registers the packed {sign, exp, frac} word together with its flags.
//
// Parameters:
//   EXP_W  exponent width (default 5)
//   MAN_W  stored fraction width (default 10)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   in_sign           result sign
//   in_exp            biased exponent (0 = subnormal)
//   in_mant           {hidden, fraction[MAN_W], G, R, S}
//   in_rm             00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   in_nan, in_inf    special-value flags (NaN wins)
//   out_valid/out_ready downstream handshake
//   out_result        {sign, exp, frac}
//   out_overflow, out_underflow, out_inexact  flags for out_result
//
// Build option:
//   FP_ROUND_FTZ_EN   flush every result with final exponent 0 to signed
//                     zero; underflow and inexact report a nonzero flush.
// ---------------------------------------------------------------------------
module fp_round_pack_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+3:0]       in_mant,
    input  logic [1:0]             in_rm,
    input  logic                   in_nan,
    input  logic                   in_inf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_inexact
);

    localparam int RW = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ONES   = '1;
    localparam logic [EXP_W-1:0] EXP_MAX    = EXP_ONES - 1'b1;
    localparam logic [EXP_W:0]   EXP_ONES_W = {1'b0, EXP_ONES};
    localparam logic [EXP_W:0]   EXP_ONE_W  = {{EXP_W{1'b0}}, 1'b1};

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // ---------------- handshake ----------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_en;
    logic s2_en;

    assign s2_en     = ~s2_valid_q | out_ready;
    assign s1_en     = ~s1_valid_q | s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid_q;

    // ---------------- stage 1: rounding ----------------
    logic             g_bit, r_bit, s_bit, l_bit, any_d, inc_d;
    logic [MAN_W+1:0] rsig_d;

    assign l_bit = in_mant[3];
    assign g_bit = in_mant[2];
    assign r_bit = in_mant[1];
    assign s_bit = in_mant[0];
    assign any_d = g_bit | r_bit | s_bit;

    always_comb begin
        inc_d = 1'b0;
        case (in_rm)
            RM_RNE:  inc_d = g_bit & (r_bit | s_bit | l_bit);
            RM_RTZ:  inc_d = 1'b0;
            RM_RUP:  inc_d = ~in_sign & any_d;
            RM_RDN:  inc_d = in_sign & any_d;
            default: inc_d = 1'b0;
        endcase
    end

    assign rsig_d = {1'b0, in_mant[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc_d};

    logic             s1_sign_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MAN_W+1:0] s1_rsig_q;
    logic [1:0]       s1_rm_q;
    logic             s1_inexact_q;
    logic             s1_nan_q;
    logic             s1_inf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_rsig_q    <= '0;
            s1_rm_q      <= '0;
            s1_inexact_q <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q    <= in_sign;
                s1_exp_q     <= in_exp;
                s1_rsig_q    <= rsig_d;
                s1_rm_q      <= in_rm;
                s1_inexact_q <= any_d;
                s1_nan_q     <= in_nan;
                s1_inf_q     <= in_inf;
            end
        end
    end

    // ---------------- stage 2: adjust and pack ----------------
    logic [EXP_W:0]   exp_adj;
    logic [MAN_W-1:0] frac_adj;
    logic [RW-1:0]    max_fin;
    logic [RW-1:0]    inf_val;
    logic [RW-1:0]    qnan_val;
    logic             to_inf;
    logic [RW-1:0]    result_d;
    logic             overflow_d;
    logic             underflow_d;
    logic             inexact_d;

    assign max_fin  = {s1_sign_q, EXP_MAX, {MAN_W{1'b1}}};
    assign inf_val  = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
    assign qnan_val = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Whether an overflowing result saturates to infinity or to max finite.
    always_comb begin
        to_inf = 1'b1;
        case (s1_rm_q)
            RM_RNE:  to_inf = 1'b1;
            RM_RTZ:  to_inf = 1'b0;
            RM_RUP:  to_inf = ~s1_sign_q;
            RM_RDN:  to_inf = s1_sign_q;
            default: to_inf = 1'b1;
        endcase
    end

    always_comb begin
        exp_adj  = {1'b0, s1_exp_q};
        frac_adj = s1_rsig_q[MAN_W-1:0];
        if (s1_rsig_q[MAN_W+1]) begin
            // Rounding carried out of the significand: 1.111..+ulp = 10.000..
            exp_adj  = {1'b0, s1_exp_q} + EXP_ONE_W;
            frac_adj = '0;
        end else if ((s1_exp_q == '0) && s1_rsig_q[MAN_W]) begin
            // Largest subnormal rounded up into the smallest normal.
            exp_adj = EXP_ONE_W;
        end
    end

    always_comb begin
        result_d    = {s1_sign_q, exp_adj[EXP_W-1:0], frac_adj};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = s1_inexact_q;
        if (s1_nan_q) begin
            result_d  = qnan_val;
            inexact_d = 1'b0;
        end else if (s1_inf_q) begin
            result_d  = inf_val;
            inexact_d = 1'b0;
        end else if (exp_adj >= EXP_ONES_W) begin
            overflow_d = 1'b1;
            inexact_d  = 1'b1;
            result_d   = to_inf ? inf_val : max_fin;
        end else if (exp_adj == '0) begin
`ifdef FP_ROUND_FTZ_EN
            result_d    = {s1_sign_q, {(RW-1){1'b0}}};
            underflow_d = (frac_adj != '0) | s1_inexact_q;
            inexact_d   = (frac_adj != '0) | s1_inexact_q;
`else
            // Tininess after rounding: exact subnormals do not underflow.
            underflow_d = s1_inexact_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_result    <= result_d;
                out_overflow  <= overflow_d;
                out_underflow <= underflow_d;
                out_inexact   <= inexact_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack_pipe.sv
module tb_fp_round_pack_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [13:0] in_mant;
    logic [1:0]  in_rm;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;

    fp_round_pack_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_rm         (in_rm),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level rounding of a half-precision magnitude.
    // Returns {result[15:0], overflow, underflow, inexact}.
    function automatic logic [18:0] ref_model(input logic sign, input logic [4:0] e_in,
                                              input logic [13:0] mant, input logic [1:0] rm,
                                              input logic nan, input logic inf);
        int unsigned sig, rem, r, e;
        bit          any, up, to_inf;
        logic [15:0] res;
        logic        ov, uf, inx;
        if (nan) return {16'h7E00, 3'b000};
        if (inf) return {sign, 5'h1F, 10'h000, 3'b000};
        sig = int'(mant) / 8;
        rem = int'(mant) % 8;
        any = (rem != 0);
        case (rm)
            2'd0:    up = (rem > 4) || (rem == 4 && (sig % 2) == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = !sign && any;
            default: up = sign && any;
        endcase
        r = sig + (up ? 1 : 0);
        e = int'(e_in);
        if (r >= 2048) begin
            r = r / 2;
            e = e + 1;
        end
        if (e == 0 && r >= 1024) e = 1;
        ov = 1'b0; uf = 1'b0; inx = any;
        if (e >= 31) begin
            to_inf = (rm == 2'd0) || (rm == 2'd2 && !sign) || (rm == 2'd3 && sign);
            ov  = 1'b1;
            inx = 1'b1;
            res = to_inf ? {sign, 5'h1F, 10'h000} : {sign, 5'h1E, 10'h3FF};
        end else begin
            res = {sign, e[4:0], r[9:0]};
            if (e == 0) begin
`ifdef FP_ROUND_FTZ_EN
                res = {sign, 15'h0000};
                uf  = (r != 0) || any;
                inx = uf;
`else
                uf = any;
`endif
            end
        end
        return {res, ov, uf, inx};
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        in_rm    = '0;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
    endtask

    task automatic rand_inputs();
        logic [9:0] frac;
        logic [2:0] grs;
        int         kind;
        in_sign = 1'($urandom_range(0, 1));
        in_rm   = 2'($urandom_range(0, 3));
        frac    = 10'($urandom);
        grs     = 3'($urandom);
        kind    = $urandom_range(0, 15);
        case (kind)
            0, 1:    in_exp = 5'd0;
            2:       begin in_exp = 5'd30; frac = 10'h3FF; end
            3:       begin in_exp = 5'd0;  frac = 10'h3FF; end
            default: in_exp = 5'($urandom_range(1, 30));
        endcase
        in_mant = {(in_exp != 0), frac, grs};
        in_nan  = ($urandom_range(0, 15) == 0);
        in_inf  = ($urandom_range(0, 15) == 0);
    endtask

    // Drives one transaction with an empty pipe and waits (bounded) for the result.
    task automatic send_one(input logic sign, input logic [4:0] e, input logic [13:0] mant,
                            input logic [1:0] rm, input logic nan, input logic inf,
                            output logic [18:0] got, output int cycles);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = sign;
        in_exp    = e;
        in_mant   = mant;
        in_rm     = rm;
        in_nan    = nan;
        in_inf    = inf;
        @(negedge clk);
        idle_inputs();
        cycles = 1;
        while (!out_valid && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        got = {out_result, out_overflow, out_underflow, out_inexact};
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if ({out_result, out_overflow, out_underflow, out_inexact} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b%b%b want=0000/000",
                     out_result, out_overflow, out_underflow, out_inexact);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    typedef struct {
        string       name;
        logic        sign;
        logic [4:0]  e;
        logic [13:0] mant;
        logic [1:0]  rm;
        logic        nan;
        logic        inf;
        logic [15:0] res;
        logic [2:0]  flags;  // {overflow, underflow, inexact}
    } vec_t;

    task automatic test_directed();
        vec_t        v[$];
        logic [18:0] got;
        int          cycles;
        v.push_back('{"rne_tie_odd",    0, 15, 14'h200C, 0, 0, 0, 16'h3C02, 3'b001});
        v.push_back('{"rne_tie_even",   0, 15, 14'h2004, 0, 0, 0, 16'h3C00, 3'b001});
        v.push_back('{"mant_carry",     0, 15, 14'h3FFE, 0, 0, 0, 16'h4000, 3'b001});
        v.push_back('{"ovf_rne",        0, 30, 14'h3FFC, 0, 0, 0, 16'h7C00, 3'b101});
        v.push_back('{"ovf_rne_neg",    1, 30, 14'h3FFC, 0, 0, 0, 16'hFC00, 3'b101});
        v.push_back('{"near_ovf_rtz",   0, 30, 14'h3FFC, 1, 0, 0, 16'h7BFF, 3'b001});
        v.push_back('{"near_ovf_rup_n", 1, 30, 14'h3FFC, 2, 0, 0, 16'hFBFF, 3'b001});
        v.push_back('{"ovf_rup_pos",    0, 30, 14'h3FFC, 2, 0, 0, 16'h7C00, 3'b101});
        v.push_back('{"near_ovf_rdn_p", 0, 30, 14'h3FFC, 3, 0, 0, 16'h7BFF, 3'b001});
        v.push_back('{"ovf_rdn_neg",    1, 30, 14'h3FFF, 3, 0, 0, 16'hFC00, 3'b101});
        v.push_back('{"sub_promote",    0,  0, 14'h1FFC, 0, 0, 0, 16'h0400, 3'b001});
`ifdef FP_ROUND_FTZ_EN
        v.push_back('{"sub_inexact",    0,  0, 14'h000C, 0, 0, 0, 16'h0000, 3'b011});
        v.push_back('{"sub_exact",      0,  0, 14'h0008, 0, 0, 0, 16'h0000, 3'b011});
`else
        v.push_back('{"sub_inexact",    0,  0, 14'h000C, 0, 0, 0, 16'h0002, 3'b011});
        v.push_back('{"sub_exact",      0,  0, 14'h0008, 0, 0, 0, 16'h0001, 3'b000});
`endif
        v.push_back('{"exact_zero",     0,  0, 14'h0000, 0, 0, 0, 16'h0000, 3'b000});
        v.push_back('{"nan_and_inf",    1, 20, 14'h2345, 0, 1, 1, 16'h7E00, 3'b000});
        v.push_back('{"inf_neg",        1, 20, 14'h2345, 2, 0, 1, 16'hFC00, 3'b000});
        foreach (v[i]) begin
            send_one(v[i].sign, v[i].e, v[i].mant, v[i].rm, v[i].nan, v[i].inf, got, cycles);
            checks++;
            if (cycles !== 2) begin
                errors++; $display("FAIL %s_latency got=%0d want=2", v[i].name, cycles);
            end
            checks++;
            if (got[18:3] !== v[i].res) begin
                errors++; $display("FAIL %s_result got=%h want=%h", v[i].name, got[18:3], v[i].res);
            end
            checks++;
            if (got[2:0] !== v[i].flags) begin
                errors++; $display("FAIL %s_flags got=%b want=%b", v[i].name, got[2:0], v[i].flags);
            end
        end
    endtask

    // Random traffic with random backpressure, scoreboarded against the model.
    task automatic test_random_stream(input int n_txn);
        logic [18:0] expq[$];
        logic [18:0] held;
        logic [18:0] cur;
        logic [18:0] want;
        bit          held_valid;
        int          sent, cyc;
        sent = 0; cyc = 0; held_valid = 0; held = '0;
        while ((sent < n_txn || expq.size() > 0) && cyc < 20 * n_txn + 100) begin
            @(negedge clk);
            cur = {out_result, out_overflow, out_underflow, out_inexact};
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold got=%b/%h want=1/%h", out_valid, cur, held);
                end
            end
            if (sent < n_txn && $urandom_range(0, 3) != 0) begin
                rand_inputs();
                in_valid = 1'b1;
            end else begin
                idle_inputs();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            held_valid = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stream_extra got=%h want=none", cur);
                end else begin
                    want = expq.pop_front();
                    if (cur !== want) begin
                        errors++; $display("FAIL stream_result got=%h want=%h", cur, want);
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_model(in_sign, in_exp, in_mant, in_rm, in_nan, in_inf));
                sent++;
            end
            cyc++;
        end
        checks++;
        if (sent != n_txn || expq.size() != 0) begin
            errors++;
            $display("FAIL stream_drain got=sent %0d pending %0d want=sent %0d pending 0",
                     sent, expq.size(), n_txn);
        end
        idle_inputs();
        out_ready = 1'b1;
    endtask

    // Five back-to-back inputs, out_ready low during cycles 3..6.
    task automatic test_back_to_back();
        logic [18:0] expq[$];
        logic [18:0] held;
        logic [18:0] cur;
        logic [18:0] want;
        bit          held_valid, saw_stall;
        int          sent, recv;
        sent = 0; recv = 0; held_valid = 0; saw_stall = 0; held = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            cur = {out_result, out_overflow, out_underflow, out_inexact};
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL b2b_hold got=%b/%h want=1/%h", out_valid, cur, held);
                end
            end
            if (sent < 5) begin
                rand_inputs();
                in_valid = 1'b1;
            end else begin
                idle_inputs();
            end
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (cyc == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_in_ready_drop got=%b want=0", in_ready);
                end
            end
            if (!in_ready) saw_stall = 1;
            held_valid = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                checks++;
                recv++;
                want = (expq.size() > 0) ? expq.pop_front() : 19'h7FFFF;
                if (cur !== want) begin
                    errors++; $display("FAIL b2b_result got=%h want=%h", cur, want);
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_model(in_sign, in_exp, in_mant, in_rm, in_nan, in_inf));
                sent++;
            end
        end
        checks++;
        if (recv != 5 || !saw_stall) begin
            errors++; $display("FAIL b2b_count got=recv %0d stall %0d want=recv 5 stall 1", recv, saw_stall);
        end
        idle_inputs();
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        logic [18:0] got;
        logic [18:0] want;
        int          cycles;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_inputs();
            in_nan = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_async got=%b/%h want=0/0000", out_valid, out_result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after got=ready %b valid %b want=ready 1 valid 0", in_ready, out_valid);
        end
        send_one(1'b0, 5'd15, 14'h200C, 2'd0, 1'b0, 1'b0, got, cycles);
        want = ref_model(1'b0, 5'd15, 14'h200C, 2'd0, 1'b0, 1'b0);
        checks++;
        if (cycles !== 2) begin
            errors++; $display("FAIL midreset_latency got=%0d want=2", cycles);
        end
        checks++;
        if (got !== want) begin
            errors++; $display("FAIL midreset_result got=%h want=%h", got, want);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        #20;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream(400);
        test_reset_midstream();
        test_random_stream(100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
